// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: pattern codes,
// counter width and the 640x480@60 default timing.
package vga_pkg;

  // Wide enough for any line/frame length up to 4096 and for the ramp bits.
  localparam int CNT_W = 12;

  localparam logic [2:0] PAT_BLACK   = 3'd0;
  localparam logic [2:0] PAT_RED     = 3'd1;
  localparam logic [2:0] PAT_GREEN   = 3'd2;
  localparam logic [2:0] PAT_BLUE    = 3'd3;
  localparam logic [2:0] PAT_CHECKER = 3'd4;
  localparam logic [2:0] PAT_BARS    = 3'd5;
  localparam logic [2:0] PAT_RAMP    = 3'd6;
  localparam logic [2:0] PAT_WHITE   = 3'd7;

  localparam int DEF_TOTAL_COLS    = 800;
  localparam int DEF_TOTAL_ROWS    = 525;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_FRONT_PORCH_H = 16;
  localparam int DEF_SYNC_WIDTH_H  = 96;
  localparam int DEF_FRONT_PORCH_V = 10;
  localparam int DEF_SYNC_WIDTH_V  = 2;

endpackage

// File: rtl/vga_timing_counter.sv
// Raster position counter with combinational sync/active/frame-start decode.
// Optional macro VGA_TPG_BORDER_EN adds a first/last-visible-row flag.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int FRONT_PORCH_H = DEF_FRONT_PORCH_H,
  parameter int SYNC_WIDTH_H  = DEF_SYNC_WIDTH_H,
  parameter int FRONT_PORCH_V = DEF_FRONT_PORCH_V,
  parameter int SYNC_WIDTH_V  = DEF_SYNC_WIDTH_V
) (
  input  logic             clock,
  input  logic             reset,
  output logic [CNT_W-1:0] col,
  output logic             tile_row,
`ifdef VGA_TPG_BORDER_EN
  output logic             edge_row,
`endif
  output logic             hsync_on,
  output logic             vsync_on,
  output logic             active,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] COL_ACT  = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0] ROW_ACT  = CNT_W'(ACTIVE_ROWS);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(ACTIVE_COLS + FRONT_PORCH_H);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(ACTIVE_COLS + FRONT_PORCH_H + SYNC_WIDTH_H);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(ACTIVE_ROWS + FRONT_PORCH_V);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(ACTIVE_ROWS + FRONT_PORCH_V + SYNC_WIDTH_V);
`ifdef VGA_TPG_BORDER_EN
  localparam logic [CNT_W-1:0] ROW_LAST_ACT = CNT_W'(ACTIVE_ROWS - 1);
`endif

  logic [CNT_W-1:0] row;

  // Column runs every clock; row advances on column wrap and wraps per frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (col == COL_LAST) begin
      col <= '0;
      row <= (row == ROW_LAST) ? '0 : row + 1'b1;
    end else begin
      col <= col + 1'b1;
    end
  end

  // Decode of the current raster position (stage p0 of the output pipe).
  always_comb begin
    hsync_on    = (col >= HS_START) && (col < HS_END);
    vsync_on    = (row >= VS_START) && (row < VS_END);
    active      = (col < COL_ACT) && (row < ROW_ACT);
    frame_start = (col == '0) && (row == '0);
    tile_row    = row[5];
`ifdef VGA_TPG_BORDER_EN
    edge_row    = (row == '0) || (row == ROW_LAST_ACT);
`endif
  end

endmodule

// File: rtl/vga_tpg.sv
// VGA test-pattern generator: per-frame pattern latch, colour generation
// and a two-stage registered output pipe aligned with sync/de/frame-start.
// Optional macro VGA_TPG_BORDER_EN forces a white one-pixel frame border.
module vga_tpg
  import vga_pkg::*;
#(
  parameter int VIDEO_WIDTH     = 3,
  parameter int TOTAL_COLS      = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS      = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS     = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS     = DEF_ACTIVE_ROWS,
  parameter int FRONT_PORCH_H   = DEF_FRONT_PORCH_H,
  parameter int SYNC_WIDTH_H    = DEF_SYNC_WIDTH_H,
  parameter int FRONT_PORCH_V   = DEF_FRONT_PORCH_V,
  parameter int SYNC_WIDTH_V    = DEF_SYNC_WIDTH_V,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             pattern_sel,
  output logic                   ohsync,
  output logic                   ovsync,
  output logic                   ode,
  output logic [VIDEO_WIDTH-1:0] oredv,
  output logic [VIDEO_WIDTH-1:0] ogrnv,
  output logic [VIDEO_WIDTH-1:0] obluv,
  output logic                   oframe_start
);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(ACTIVE_COLS / 8 - 1);
  localparam logic [VIDEO_WIDTH-1:0] ONES = '1;
`ifdef VGA_TPG_BORDER_EN
  localparam logic [CNT_W-1:0] COL_LAST_ACT = CNT_W'(ACTIVE_COLS - 1);
`endif

  logic [CNT_W-1:0] col_p0;
  logic tile_row_p0, hs_p0, vs_p0, act_p0, fs_p0;
  logic hs_p1, vs_p1, act_p1, fs_p1;
  logic [2:0] pat_q;
  logic [2:0] bar_p1;
  logic [CNT_W-1:0] bar_cnt_p1;
  logic tile_p1;
  logic [VIDEO_WIDTH-1:0] ramp_p1;
  logic [VIDEO_WIDTH-1:0] r_c, g_c, b_c;
`ifdef VGA_TPG_BORDER_EN
  logic edge_row_p0, border_p1;
`endif

  vga_timing_counter #(
    .TOTAL_COLS    (TOTAL_COLS),
    .TOTAL_ROWS    (TOTAL_ROWS),
    .ACTIVE_COLS   (ACTIVE_COLS),
    .ACTIVE_ROWS   (ACTIVE_ROWS),
    .FRONT_PORCH_H (FRONT_PORCH_H),
    .SYNC_WIDTH_H  (SYNC_WIDTH_H),
    .FRONT_PORCH_V (FRONT_PORCH_V),
    .SYNC_WIDTH_V  (SYNC_WIDTH_V)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .col         (col_p0),
    .tile_row    (tile_row_p0),
`ifdef VGA_TPG_BORDER_EN
    .edge_row    (edge_row_p0),
`endif
    .hsync_on    (hs_p0),
    .vsync_on    (vs_p0),
    .active      (act_p0),
    .frame_start (fs_p0)
  );

  // ---- stage p0 -> p1 ----
  // Control: timing flags delayed one clock; pattern captured only at (0,0)
  // so that pixel (0,0) is already drawn with the new frame's pattern.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      act_p1 <= 1'b0;
      fs_p1  <= 1'b0;
      pat_q  <= PAT_BLACK;
    end else begin
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      act_p1 <= act_p0;
      fs_p1  <= fs_p0;
      if (fs_p0) pat_q <= pattern_sel;
    end
  end

  // Data: bar index counts whole bar widths and sticks at 7, absorbing the remainder.
  always_ff @(posedge clock) begin
    tile_p1 <= col_p0[5] ^ tile_row_p0;
    ramp_p1 <= col_p0[9 -: VIDEO_WIDTH];
`ifdef VGA_TPG_BORDER_EN
    border_p1 <= edge_row_p0 || (col_p0 == '0) || (col_p0 == COL_LAST_ACT);
`endif
    if (col_p0 == '0) begin
      bar_p1     <= 3'd0;
      bar_cnt_p1 <= '0;
    end else if (bar_p1 != 3'd7) begin
      if (bar_cnt_p1 == BAR_LAST) begin
        bar_p1     <= bar_p1 + 3'd1;
        bar_cnt_p1 <= '0;
      end else begin
        bar_cnt_p1 <= bar_cnt_p1 + 1'b1;
      end
    end
  end

  // Pixel colour for the stage-p1 position; blanked outside the active area.
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (act_p1) begin
      case (pat_q)
        PAT_BLACK: ;
        PAT_RED:   r_c = ONES;
        PAT_GREEN: g_c = ONES;
        PAT_BLUE:  b_c = ONES;
        PAT_CHECKER: begin
          r_c = {VIDEO_WIDTH{tile_p1}};
          g_c = {VIDEO_WIDTH{tile_p1}};
          b_c = {VIDEO_WIDTH{tile_p1}};
        end
        PAT_BARS: begin
          r_c = {VIDEO_WIDTH{bar_p1[0]}};
          g_c = {VIDEO_WIDTH{bar_p1[1]}};
          b_c = {VIDEO_WIDTH{bar_p1[2]}};
        end
        PAT_RAMP: begin
          r_c = ramp_p1;
          g_c = ramp_p1;
          b_c = ramp_p1;
        end
        PAT_WHITE: begin
          r_c = ONES;
          g_c = ONES;
          b_c = ONES;
        end
        default: ;
      endcase
`ifdef VGA_TPG_BORDER_EN
      if (border_p1) begin
        r_c = ONES;
        g_c = ONES;
        b_c = ONES;
      end
`endif
    end
  end

  // ---- stage p1 -> p2 (outputs) ----
  // Output registers; sync polarity applied here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ohsync       <= SYNC_IDLE;
      ovsync       <= SYNC_IDLE;
      ode          <= 1'b0;
      oredv        <= '0;
      ogrnv        <= '0;
      obluv        <= '0;
      oframe_start <= 1'b0;
    end else begin
      ohsync       <= hs_p1 ? ~SYNC_IDLE : SYNC_IDLE;
      ovsync       <= vs_p1 ? ~SYNC_IDLE : SYNC_IDLE;
      ode          <= act_p1;
      oredv        <= r_c;
      ogrnv        <= g_c;
      obluv        <= b_c;
      oframe_start <= fs_p1;
    end
  end

endmodule

// File: tb/tb_vga_tpg.sv
// Bench for vga_tpg with a reduced raster (164x36, 140x33 visible) so that
// several whole frames fit in a short run. Reference pixel model below is
// written from the raster/pattern rules directly.
module tb_vga_tpg;

  localparam int VW  = 4;
  localparam int TC  = 164;
  localparam int TR  = 36;
  localparam int AC  = 140;
  localparam int AR  = 33;
  localparam int FPH = 6;
  localparam int SWH = 10;
  localparam int FPV = 1;
  localparam int SWV = 1;
  localparam int F   = TC * TR;
  localparam int BW  = AC / 8;
  localparam logic [VW-1:0] M = '1;
  localparam logic [15:0] IDLE = 16'hC000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] pattern_sel = 3'd0;
  logic ohsync, ovsync, ode, oframe_start;
  logic [VW-1:0] oredv, ogrnv, obluv;

  int total = 0;
  int bad = 0;
  int edge_cnt = -1;
  logic [2:0] pat_hist [0:15];

  vga_tpg #(
    .VIDEO_WIDTH     (VW),
    .TOTAL_COLS      (TC),
    .TOTAL_ROWS      (TR),
    .ACTIVE_COLS     (AC),
    .ACTIVE_ROWS     (AR),
    .FRONT_PORCH_H   (FPH),
    .SYNC_WIDTH_H    (SWH),
    .FRONT_PORCH_V   (FPV),
    .SYNC_WIDTH_V    (SWV),
    .SYNC_ACTIVE_LOW (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pattern_sel  (pattern_sel),
    .ohsync       (ohsync),
    .ovsync       (ovsync),
    .ode          (ode),
    .oredv        (oredv),
    .ogrnv        (ogrnv),
    .obluv        (obluv),
    .oframe_start (oframe_start)
  );

  always #5 clock = ~clock;

  // Edges since reset release; pattern request recorded at each frame start.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_cnt <= -1;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (((edge_cnt + 1) % F) == 0) pat_hist[((edge_cnt + 1) / F) % 16] <= pattern_sel;
    end
  end

  // Expected {hsync, vsync, de, frame_start, R, G, B} for raster pixel n.
  function automatic logic [15:0] model_px(input int n, input logic [2:0] pat);
    int c, r, b, v;
    logic hs_on, vs_on, act, fs;
    logic [VW-1:0] rr, gg, bb;
    c = n % TC;
    r = (n / TC) % TR;
    act   = (c < AC) && (r < AR);
    hs_on = (c >= AC + FPH) && (c < AC + FPH + SWH);
    vs_on = (r >= AR + FPV) && (r < AR + FPV + SWV);
    fs    = (c == 0) && (r == 0);
    rr = '0; gg = '0; bb = '0;
    b = c / BW;
    if (b > 7) b = 7;
    v = (c / (1 << (10 - VW))) % (1 << VW);
    if (act) begin
      case (pat)
        3'd1: rr = M;
        3'd2: gg = M;
        3'd3: bb = M;
        3'd4: if ((((c / 32) + (r / 32)) % 2) == 1) begin rr = M; gg = M; bb = M; end
        3'd5: begin
          rr = ((b % 2) == 1) ? M : '0;
          gg = (((b / 2) % 2) == 1) ? M : '0;
          bb = (((b / 4) % 2) == 1) ? M : '0;
        end
        3'd6: begin rr = VW'(v); gg = VW'(v); bb = VW'(v); end
        3'd7: begin rr = M; gg = M; bb = M; end
        default: ;
      endcase
`ifdef VGA_TPG_BORDER_EN
      if (c == 0 || c == AC - 1 || r == 0 || r == AR - 1) begin rr = M; gg = M; bb = M; end
`endif
    end
    return {!hs_on, !vs_on, act, fs, rr, gg, bb};
  endfunction

  // Every-cycle comparison of all outputs against the model.
  initial begin : compare
    logic [15:0] expv, got;
    int n;
    forever begin
      @(negedge clock);
      got = {ohsync, ovsync, ode, oframe_start, oredv, ogrnv, obluv};
      if (reset || edge_cnt < 1) begin
        expv = IDLE;
      end else begin
        n = edge_cnt - 1;
        expv = model_px(n, pat_hist[(n / F) % 16]);
      end
      total++;
      if (got !== expv) begin
        bad++;
        $display("FAIL pix t=%0t edge=%0d got=%h want=%h", $time, edge_cnt, got, expv);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic wait_edge(input int k);
    int g;
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (edge_cnt != k && g < 50);
    if (edge_cnt != k) chk("wait_edge", edge_cnt, k);
  endtask

  task automatic wait_pixel(input int c, input int r);
    int g;
    logic hit;
    g = 0;
    hit = 1'b0;
    while (!hit && g < F + 50) begin
      @(negedge clock);
      g++;
      hit = !reset && (edge_cnt >= 1) && (((edge_cnt - 1) % F) == (r * TC + c));
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_pixel (%0d,%0d) never reached", c, r);
    end
  endtask

  initial begin : stim
    int seed, nxt, lat, end_edge;
    reset = 1'b1;
    pattern_sel = 3'd5;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_de", ode, 0);
    chk("rst_hs", ohsync, 1);
    chk("rst_vs", ovsync, 1);
    chk("rst_fs", oframe_start, 0);
    chk("rst_rgb", {oredv, ogrnv, obluv}, 0);
    #1 reset = 1'b0;

    // Colour bars, first frame after release.
    wait_edge(0);
    chk("fs_clk1", oframe_start, 0);
    wait_pixel(0, 0);
    chk("fs_clk2", oframe_start, 1);
    chk("de_clk2", ode, 1);
    chk("bar0_c0", {oredv, ogrnv, obluv}, 12'h000);
    wait_pixel(16, 0);  chk("bar0_c16", {oredv, ogrnv, obluv}, 12'h000);
    wait_pixel(17, 0);  chk("bar1_c17", {oredv, ogrnv, obluv}, 12'hF00);
    wait_pixel(56, 0);  chk("bar3_c56", {oredv, ogrnv, obluv}, 12'hFF0);
    wait_pixel(119, 0); chk("bar7_c119", {oredv, ogrnv, obluv}, 12'hFFF);
    wait_pixel(139, 0); chk("bar7_c139", {oredv, ogrnv, obluv}, 12'hFFF);
    wait_pixel(140, 0); chk("blank_de", ode, 0);
    chk("blank_rgb", {oredv, ogrnv, obluv}, 0);
    wait_pixel(145, 1); chk("hs_c145", ohsync, 1);
    wait_pixel(146, 1); chk("hs_c146", ohsync, 0);
    wait_pixel(155, 1); chk("hs_c155", ohsync, 0);
    wait_pixel(156, 1); chk("hs_c156", ohsync, 1);
    wait_pixel(0, 33);  chk("vs_r33", ovsync, 1);
    wait_pixel(0, 34);  chk("vs_r34", ovsync, 0);
    wait_pixel(163, 34); chk("vs_r34_end", ovsync, 0);
    wait_pixel(0, 35);  chk("vs_r35", ovsync, 1);

    // Random mid-frame pattern churn; each frame boundary sees a chosen code.
    seed = $urandom_range(0, 7);
    end_edge = edge_cnt + 8 * F;
    while (edge_cnt < end_edge) begin
      @(posedge clock);
      #2;
      nxt = edge_cnt + 1;
      lat = (nxt + F - 1) / F;
      if (lat * F - nxt < 40) pattern_sel = 3'((lat + seed) % 8);
      else if ($urandom_range(0, 199) == 0) pattern_sel = 3'($urandom_range(0, 7));
    end

    // Reset mid-frame: outputs must drop without waiting for a clock.
    wait_pixel(100, 20);
    chk("pre_rst_de", ode, 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_de", ode, 0);
    chk("async_rgb", {oredv, ogrnv, obluv}, 0);
    chk("async_hs", ohsync, 1);
    chk("async_vs", ovsync, 1);
    chk("async_fs", oframe_start, 0);
    repeat (2) @(posedge clock);
    #2;
    pattern_sel = 3'd1;
    reset = 1'b0;
    wait_edge(0);
    chk("re_fs_clk1", oframe_start, 0);
    wait_pixel(0, 0);
    chk("re_fs_clk2", oframe_start, 1);
    chk("re_de_clk2", ode, 1);
    chk("re_rgb00", {oredv, ogrnv, obluv}, 12'hF00);

    // Request change mid-frame: current frame stays red, next is green.
    wait_pixel(0, 10);
    pattern_sel = 3'd2;
    wait_pixel(5, 20);   chk("sw_red_r20", {oredv, ogrnv, obluv}, 12'hF00);
    wait_pixel(139, 32); chk("sw_red_last", {oredv, ogrnv, obluv}, 12'hF00);
    wait_pixel(5, 5);    chk("sw_green_r5", {oredv, ogrnv, obluv}, 12'h0F0);
    wait_pixel(139, 32); chk("sw_green_last", {oredv, ogrnv, obluv}, 12'h0F0);

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_tpg.md
VGA_TPG -- requirements
Module: vga_tpg

Interface
REQ-001 SHALL have parameter VIDEO_WIDTH, default 3, meaning bits per colour channel.
REQ-002 SHALL have parameter TOTAL_COLS, default 800, meaning clocks per line.
REQ-003 SHALL have parameter TOTAL_ROWS, default 525, meaning lines per frame.
REQ-004 SHALL have parameter ACTIVE_COLS, default 640, meaning visible pixels per line.
REQ-005 SHALL have parameter ACTIVE_ROWS, default 480, meaning visible lines per frame.
REQ-006 SHALL have parameters FRONT_PORCH_H 16, SYNC_WIDTH_H 96, FRONT_PORCH_V 10, SYNC_WIDTH_V 2, meaning porch and sync lengths in clocks and lines.
REQ-007 SHALL have parameter SYNC_ACTIVE_LOW, default 1, meaning the asserted sync level is 0 when set and 1 when clear.
REQ-008 Ports, one per line:
  clock  in  1  pixel clock; the block's only clock
  reset  in  1  asynchronous, active-high reset
  pattern_sel  in  3  pattern request
  ohsync  out  1  horizontal sync
  ovsync  out  1  vertical sync
  ode  out  1  active-video data enable
  oredv/ogrnv/obluv  out  VIDEO_WIDTH each  pixel colour
  oframe_start  out  1  one-cycle pulse on pixel (0,0)

Function
REQ-009 col SHALL count 0..TOTAL_COLS-1 and wrap to 0; row SHALL increment when col wraps and wrap to 0 after TOTAL_ROWS-1.
REQ-010 Active region: col<ACTIVE_COLS and row<ACTIVE_ROWS.
REQ-011 hsync SHALL be asserted for col in [ACTIVE_COLS+FRONT_PORCH_H, ACTIVE_COLS+FRONT_PORCH_H+SYNC_WIDTH_H).
REQ-012 vsync SHALL be asserted for row in [ACTIVE_ROWS+FRONT_PORCH_V, ACTIVE_ROWS+FRONT_PORCH_V+SYNC_WIDTH_V), for whole lines.
REQ-013 All outputs SHALL be registered, with a fixed 2-clock latency from counter value to output; sync, ode, colour and oframe_start SHALL be mutually aligned.
REQ-014 pattern_sel SHALL be latched only when the counters reach (0,0); mid-frame changes SHALL take effect at the next frame.
REQ-015 Patterns by latched pattern_sel value:
  0 = black
  1 = red all-ones
  2 = green all-ones
  3 = blue all-ones
  4 = checkerboard, white where col[5]^row[5], else black
  5 = eight colour bars, bar index b, red=b[0], green=b[1], blue=b[2], each set channel at all-ones
  6 = horizontal grey ramp, all channels = col[9:10-VIDEO_WIDTH]
  7 = white
REQ-016 Bar width SHALL be ACTIVE_COLS/8, computed at elaboration; the bar index SHALL be held by a counter, not by a divider, and SHALL saturate at 7, so the remainder columns belong to bar 7.
REQ-017 Outside the active region, colour SHALL be 0 and ode SHALL be 0, regardless of pattern.

Reset
REQ-018 While reset is high: counters at 0, latched pattern 0, sync outputs at inactive level, ode=0, colours=0, oframe_start=0; all asynchronous.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately; after release, counting SHALL restart at (0,0) and oframe_start SHALL pulse 2 clocks later.

Configuration
REQ-020 With VGA_TPG_BORDER_EN defined, active pixels on col 0, col ACTIVE_COLS-1, row 0 or row ACTIVE_ROWS-1 SHALL be forced to all-ones on every channel, overriding every pattern.
REQ-021 Without VGA_TPG_BORDER_EN, there SHALL be no overlay and no border logic.

Structure
REQ-022 Shared package vga_pkg SHALL hold the pattern code constants (PAT_BLACK..PAT_WHITE) and the 640x480 default timing constants.
REQ-023 Sub-module vga_timing_counter SHALL own col/row, sync, active and frame-start generation; vga_tpg SHALL own pattern latch, colour generation and the output pipeline.

Verification (defaults, SYNC_ACTIVE_LOW=1)
REQ-024 Reset then free-run -> hsync low exactly at cols 656..751 of every line (96 clk); vsync low rows 490..491 (1600 clk); frame period 420000 clk.
REQ-025 pattern_sel=1 -> every ode=1 pixel has R=7,G=0,B=0; every ode=0 pixel has RGB=0; ode high 640 clk per visible line, 480 lines.
REQ-026 Switch pattern_sel 1->2 at row 100 -> rows 100..479 remain red; next frame all green.
REQ-027 pattern_sel=5 -> cols 0..79 RGB=0; col 80 R=7 only; cols 560..639 RGB=7,7,7.
REQ-028 Assert reset at row 200 col 300 -> outputs go to reset values in the same cycle; after release, oframe_start high exactly at clock 2, with ode=1 and pixel (0,0) colour.
REQ-029 VGA_TPG_BORDER_EN, pattern_sel=0 -> pixels (0,0), (639,479) and (320,0) white; pixel (1,1) black; without the macro, (0,0) is black.
